music_beat_ctrl: RTL and testbench
==================================

// Module: music_beat_ctrl
// PURPOSE
//  Beat sequencer that drives the song tone ROMs: produces the 10-bit quarter-beat index
//  (beat_num) consumed by the Music_* note tables. Handles start/stop/pause, one-shot or
//  loop playback and per-song length. Also flags mute so the downstream tone path plays silence.
// PARAMETERS
//  CLK_HZ   100_000_000  system clock frequency
//  BEAT_HZ  8            quarter-beat index rate (index advances per second)
//  BEAT_W   10           width of beat_num, matches tone ROM index
//  TICK_DIV CLK_HZ/BEAT_HZ (localparam) clocks per index step; must be >= 2
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous reset, active-high
//  start     in   1       pulse: (re)start song from index 0
//  stop      in   1       pulse: abort, return to idle
//  pause     in   1       level: freeze playback while high
//  loop_en   in   1       1 = wrap to 0 after last index, 0 = one-shot
//  song_last in   BEAT_W  last valid index of selected song (e.g. 127)
//  beat_num  out  BEAT_W  current index to tone ROM
//  playing   out  1       high in PLAY state
//  mute      out  1       high unless in PLAY; downstream forces silence (20000 Hz tone)
//  done      out  1       one-cycle pulse when a one-shot song ends
//  wrap      out  1       one-cycle pulse when a looped song wraps to 0
// BEHAVIOUR
//  - Reset: state IDLE, beat_num 0, prescaler 0, playing 0, mute 1, done 0, wrap 0.
//  - States: IDLE, PLAY, PAUSE. All outputs registered.
//  - Priority per cycle: rst > stop > start > pause > tick.
//  - start (any state): next state PLAY, beat_num 0, prescaler 0, song_last latched into
//    last_q; later song_last changes ignored until next start.
//  - stop (any state): IDLE, beat_num 0, prescaler 0; no done pulse.
//  - PLAY: prescaler counts 0..TICK_DIV-1; tick = (prescaler==TICK_DIV-1), prescaler wraps.
//    On tick: beat_num<last_q -> beat_num+1; beat_num==last_q & loop_en -> beat_num 0, wrap=1;
//    beat_num==last_q & !loop_en -> IDLE, beat_num 0, done=1.
//  - First index held exactly TICK_DIV cycles after start; each later index TICK_DIV cycles.
//  - pause high in PLAY -> PAUSE at that edge; prescaler and beat_num frozen. pause low in
//    PAUSE -> PLAY, count resumes from frozen prescaler value. pause ignored in IDLE.
//  - pause and tick same cycle: pause wins, index not advanced.
//  - start while pause high: enter PLAY, then PAUSE next cycle (pause rule applies).
//  - last_q==0: index stays 0; each tick yields wrap or done.
//  - Mid-song loop_en change takes effect at the next end-of-song tick.
// CONFIGURATION
//  - MUSIC_TEMPO_ADJ_EN defined: adds input tempo_sel[1:0] (00 x1, 01 x2, 10 x0.5, 11 x1).
//    Terminal count = TICK_DIV-1, TICK_DIV/2-1, 2*TICK_DIV-1; tempo_sel sampled at start.
//  - Undefined: no tempo_sel port, fixed TICK_DIV.
// STRUCTURE
//  - music_pkg: state enum (IDLE/PLAY/PAUSE), BEAT_W, silence tone constant 20000.
//  - Sub-module beat_tick_gen: prescaler with clear/enable/terminal-count in, tick out.
//  - Top holds FSM, beat_num counter, last_q, done/wrap pulses.
// TESTING (sim with CLK_HZ=16, BEAT_HZ=4 -> TICK_DIV=4)
//  1 rst high 3 cycles -> beat_num 0, mute 1, playing 0, done 0.
//  2 song_last=3, loop_en=0, start -> beat_num 0,1,2,3 each 4 cycles, then done 1 cycle,
//    IDLE, beat_num 0, mute 1.
//  3 song_last=2, loop_en=1 -> sequence 0,1,2,0,... wrap pulse at each 2->0, no done.
//  4 pause high 6 cycles at beat_num 1 -> beat_num held 1, mute 1; after release index 2
//    appears after the remaining prescaler count (total 4 PLAY cycles in index 1).
//  5 stop and start same cycle during PLAY -> stop wins: IDLE, beat_num 0, no done.
//  6 start mid-song at beat_num 2 with song_last changed 3->1 -> restart at 0, end after 1.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and constants for the music beat sequencer.
package music_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int BEAT_W_DEF = 10;
  // Tone frequency the downstream path substitutes while mute is high
  localparam int SILENCE_HZ = 20000;

endpackage

// File: rtl/beat_tick_gen.sv
// Prescaler for the beat sequencer: counts 0..tc while enabled, flags the
// terminal count and wraps back to zero on it.
module beat_tick_gen #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic [CW-1:0] tc,
  output logic          tick
);

  logic [CW-1:0] cnt;

  assign tick = (cnt == tc);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/music_beat_ctrl.sv
// Beat sequencer producing the quarter-beat index for the tone ROMs.
// Optional MUSIC_TEMPO_ADJ_EN adds tempo_sel (x1/x2/x0.5), sampled at start.
module music_beat_ctrl
  import music_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BEAT_HZ = 8,
  parameter int BEAT_W  = BEAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [BEAT_W-1:0] song_last,
`ifdef MUSIC_TEMPO_ADJ_EN
  input  logic [1:0]        tempo_sel,
`endif
  output logic [BEAT_W-1:0] beat_num,
  output logic              playing,
  output logic              mute,
  output logic              done,
  output logic              wrap
);

  localparam int TICK_DIV = CLK_HZ / BEAT_HZ;
  // Wide enough for the slowest tempo terminal count, 2*TICK_DIV-1
  localparam int CW = $clog2(2 * TICK_DIV);
  localparam logic [CW-1:0] TC_X1 = CW'(TICK_DIV - 1);

  state_t            state_q;
  logic [BEAT_W-1:0] last_q;
  logic [CW-1:0]     tc;
  logic              tick;
  logic              count_en;
  logic              clear;

`ifdef MUSIC_TEMPO_ADJ_EN
  localparam logic [CW-1:0] TC_X2  = CW'(TICK_DIV / 2 - 1);
  localparam logic [CW-1:0] TC_X05 = CW'(2 * TICK_DIV - 1);
  logic [CW-1:0] tc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q <= TC_X1;
    end else if (start && !stop) begin
      case (tempo_sel)
        2'b01:   tc_q <= TC_X2;
        2'b10:   tc_q <= TC_X05;
        default: tc_q <= TC_X1;
      endcase
    end
  end

  assign tc = tc_q;
`else
  assign tc = TC_X1;
`endif

  assign clear    = stop || start;
  assign count_en = (state_q == ST_PLAY) && !stop && !start && !pause;

  beat_tick_gen #(.CW(CW)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (count_en),
    .tc    (tc),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_num <= '0;
      last_q   <= '0;
      playing  <= 1'b0;
      mute     <= 1'b1;
      done     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (stop) begin
        state_q  <= ST_IDLE;
        beat_num <= '0;
        playing  <= 1'b0;
        mute     <= 1'b1;
      end else if (start) begin
        state_q  <= ST_PLAY;
        beat_num <= '0;
        last_q   <= song_last;
        playing  <= 1'b1;
        mute     <= 1'b0;
      end else begin
        case (state_q)
          ST_PLAY: begin
            if (pause) begin
              state_q <= ST_PAUSE;
              playing <= 1'b0;
              mute    <= 1'b1;
            end else if (tick) begin
              if (beat_num < last_q) begin
                beat_num <= beat_num + 1'b1;
              end else if (loop_en) begin
                beat_num <= '0;
                wrap     <= 1'b1;
              end else begin
                state_q  <= ST_IDLE;
                beat_num <= '0;
                playing  <= 1'b0;
                mute     <= 1'b1;
                done     <= 1'b1;
              end
            end
          end
          ST_PAUSE: begin
            if (!pause) begin
              state_q <= ST_PLAY;
              playing <= 1'b1;
              mute    <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_beat_ctrl.sv
// Scoreboard bench for music_beat_ctrl: a behavioural player model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_music_beat_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [9:0] song_last = '0;
  logic [9:0] beat_num;
  logic       playing, mute, done, wrap;

  music_beat_ctrl #(.CLK_HZ(16), .BEAT_HZ(4), .BEAT_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .song_last (song_last),
    .beat_num  (beat_num),
    .playing   (playing),
    .mute      (mute),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];

  // Model: mode 0 idle, 1 playing, 2 paused; age = cycles spent counting in this index
  int       m_mode = 0;
  int       m_age  = 0;
  int       m_idx  = 0;
  int       m_last = 0;
  logic     m_done, m_wrap;

  task automatic model_step();
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (rst || stop) begin
      m_mode = 0; m_idx = 0; m_age = 0;
    end else if (start) begin
      m_mode = 1; m_idx = 0; m_age = 0; m_last = int'(song_last);
    end else if (m_mode == 1 && pause) begin
      m_mode = 2;
    end else if (m_mode == 2 && !pause) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_age++;
      if (m_age == TD) begin
        m_age = 0;
        if (m_idx < m_last) m_idx++;
        else if (loop_en) begin m_idx = 0; m_wrap = 1'b1; end
        else begin m_idx = 0; m_mode = 0; m_done = 1'b1; end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic t, input logic p,
                     input logic l, input logic [9:0] sl);
    logic [9:0] ei;
    @(negedge clk);
    rst = r; start = s; stop = t; pause = p; loop_en = l; song_last = sl;
    model_step();
    ei = 10'(m_idx);
    exp_q.push_back({ei, m_mode == 1, m_mode != 1, m_done, m_wrap});
  endtask

  task automatic idle(input int n, input logic p, input logic l, input logic [9:0] sl);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, p, l, sl);
  endtask

  always @(posedge clk) begin
    logic [13:0] got, e;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {beat_num, playing, mute, done, wrap};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got beat=%0d play=%0b mute=%0b done=%0b wrap=%0b exp beat=%0d play=%0b mute=%0b done=%0b wrap=%0b",
                 $time, got[13:4], got[3], got[2], got[1], got[0],
                 e[13:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    logic pz, lp, s, t, r;
    logic [9:0] sl;
    // reset for three cycles
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
    idle(2, 1'b1, 1'b0, 10'd0);
    // one-shot song of four indices
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd3);
    idle(22, 1'b0, 1'b0, 10'd3);
    // looped song wrapping after index 2
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd2);
    idle(30, 1'b0, 1'b1, 10'd2);
    // pause held six cycles inside index 1
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd3);
    idle(5, 1'b0, 1'b0, 10'd3);
    idle(6, 1'b1, 1'b0, 10'd3);
    idle(20, 1'b0, 1'b0, 10'd3);
    // stop and start together mid-song
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd3);
    idle(6, 1'b0, 1'b0, 10'd3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd3);
    idle(5, 1'b0, 1'b0, 10'd3);
    // restart at index 2 with a shorter song, then song_last changes are ignored
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd3);
    idle(9, 1'b0, 1'b0, 10'd3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd1);
    idle(14, 1'b0, 1'b0, 10'd5);
    // zero-length song, looped then one-shot; start while pause high
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0);
    idle(10, 1'b0, 1'b1, 10'd0);
    idle(6, 1'b0, 1'b0, 10'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd2);
    idle(4, 1'b1, 1'b0, 10'd2);
    idle(16, 1'b0, 1'b0, 10'd2);
    // randomized traffic
    pz = 1'b0; lp = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 14) == 0) pz = ~pz;
      if ($urandom_range(0, 49) == 0) lp = ~lp;
      s  = ($urandom_range(0, 39) == 0);
      t  = ($urandom_range(0, 119) == 0);
      r  = ($urandom_range(0, 499) == 0);
      sl = 10'($urandom_range(0, 5));
      cyc(r, s, t, pz, lp, sl);
    end
    idle(3, 1'b0, 1'b0, 10'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
